// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32 constants: the datapath width and the RV32M funct3 encodings
// used by both the ALU-control stage and the multiply/divide unit.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    // RV32M funct3 encodings for the M-extension operations.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. Operands are converted to magnitudes
// at capture, processed one bit per cycle (shift-add multiply or restoring
// divide) over 32 cycles, then sign-corrected and registered.
// Divide-by-zero and signed overflow bypass the iteration and finish in one
// cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      operation request, accepted only while idle
//   muldiv_op  RV32M funct3 selecting the operation
//   op_a       rs1 value (multiplicand / dividend)
//   op_b       rs2 value (multiplier / divisor)
//   busy       high while an operation is in flight (not idle)
//   done       one-cycle pulse when result is updated
//   result     registered result, held until the next done
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      muldiv_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import riscv_pkg::*;

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_e;

    state_e state, state_nxt;

    // Captured operation context
    muldiv_op_e        op_in, op_r;
    logic              sign_a, sign_b;
    logic              fast_r;
    logic [XLEN-1:0]   fast_res_r;

    // Iteration datapath. work holds the shifting multiplier for multiply,
    // and the dividend-shifting-into-quotient for divide.
    logic [XLEN-1:0]   work;
    logic [XLEN-1:0]   divisor;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [CNT_W-1:0]  cnt;

    // Capture-time decode
    logic              a_signed_in, b_signed_in;
    logic              div_zero_in, ovf_in, fast_in;
    logic [XLEN-1:0]   a_mag_in, b_mag_in, fast_res_in;

    // Per-iteration and fix-up values
    logic [XLEN:0]     shifted, diff;
    logic [2*XLEN-1:0] acc_add, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, res_sel;

    assign op_in = muldiv_op_e'(muldiv_op);
    assign busy  = (state != S_IDLE);

    always_comb begin
        a_signed_in = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed_in = op_in inside {OP_MULH, OP_DIV, OP_REM};
        a_mag_in    = (a_signed_in && op_a[XLEN-1]) ? -op_a : op_a;
        b_mag_in    = (b_signed_in && op_b[XLEN-1]) ? -op_b : op_b;
        div_zero_in = muldiv_op[2] && (op_b == '0);
        ovf_in      = (op_in inside {OP_DIV, OP_REM}) && (op_a == MIN_NEG) && (op_b == '1);
        fast_in     = div_zero_in || ovf_in;
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero_in) begin
            fast_res_in = muldiv_op[1] ? op_a : '1;
        end else begin
            fast_res_in = muldiv_op[1] ? '0 : MIN_NEG;
        end
    end

    // Restoring divide step: the 33-bit trial remainder is the stored
    // remainder shifted left with the next dividend bit. A borrow out of
    // bit XLEN means the divisor does not fit and the remainder is kept.
    // The stored remainder is always below the divisor, so XLEN bits hold it.
    always_comb begin
        shifted = {rem, work[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        acc_add = work[0] ? mcand : '0;
    end

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix  = (sign_a ^ sign_b) ? -work : work;
        rem_fix  = sign_a ? -rem : rem;
        res_sel  = rem_fix;
        case (op_r)
            OP_MUL:                         res_sel = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   res_sel = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                res_sel = quo_fix;
            default:                        res_sel = rem_fix;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = fast_in ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == CNT_W'(XLEN-1)) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            result     <= '0;
            cnt        <= '0;
            op_r       <= OP_MUL;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            fast_r     <= 1'b0;
            fast_res_r <= '0;
            work       <= '0;
            divisor    <= '0;
            mcand      <= '0;
            acc        <= '0;
            rem        <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == S_FIN);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r       <= op_in;
                        sign_a     <= a_signed_in && op_a[XLEN-1];
                        sign_b     <= b_signed_in && op_b[XLEN-1];
                        fast_r     <= fast_in;
                        fast_res_r <= fast_res_in;
                        cnt        <= '0;
                        acc        <= '0;
                        rem        <= '0;
                        mcand      <= {{XLEN{1'b0}}, a_mag_in};
                        divisor    <= b_mag_in;
                        work       <= muldiv_op[2] ? a_mag_in : b_mag_in;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_r[2]) begin
                        if (diff[XLEN]) begin
                            rem  <= shifted[XLEN-1:0];
                            work <= {work[XLEN-2:0], 1'b0};
                        end else begin
                            rem  <= diff[XLEN-1:0];
                            work <= {work[XLEN-2:0], 1'b1};
                        end
                    end else begin
                        acc   <= acc + acc_add;
                        mcand <= {mcand[2*XLEN-2:0], 1'b0};
                        work  <= {1'b0, work[XLEN-1:1]};
                    end
                end
                S_FIN: begin
                    result <= fast_r ? fast_res_r : res_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: directed RV32M cases, randomized
// operations against an arithmetic reference model, start-while-busy,
// back-to-back issue and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  muldiv_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int passes = 0;
    int checks = 0;
    int fails  = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .muldiv_op (muldiv_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: RV32M semantics from plain wide arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ai, bi;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ai = a;
        bi = b;
        r  = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = ai / bi;
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = ai % bi;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drive a request so that it is sampled at the next rising edge (edge N);
    // returns 1ns after edge N.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        muldiv_op = op;
        op_a      = a;
        op_b      = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done counting edges after the current one; lat=-1 on timeout.
    task automatic wait_done(input int first, output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = first; i <= first + 45; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp_r;
        int          exp_l;
        int          lat;
        logic        busy_ok;
        exp_r = ref_res(op, a, b);
        exp_l = ref_lat(op, a, b);
        issue(op, a, b);
        check({tag, "/busy_at_start"}, 64'(busy), 64'(1'b1));
        wait_done(1, lat, busy_ok);
        check({tag, "/latency"}, 64'(lat), 64'(exp_l));
        check({tag, "/result"}, 64'(result), 64'(exp_r));
        check({tag, "/busy_held"}, 64'(busy_ok), 64'(1'b1));
        check({tag, "/busy_in_done"}, 64'(busy), 64'(1'b0));
        @(posedge clk);
        #1;
        check({tag, "/done_one_cycle"}, 64'(done), 64'(1'b0));
        check({tag, "/result_held"}, 64'(result), 64'(exp_r));
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] specials [5];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int          lat;
        int          pulses;
        logic        busy_ok;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst_n     = 1'b0;
        start     = 1'b1;
        muldiv_op = 3'd0;
        op_a      = 32'd3;
        op_b      = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", 64'(busy), 64'(1'b0));
        check("reset/done", 64'(done), 64'(1'b0));
        check("reset/result", 64'(result), 64'h0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset/start_ignored", 64'(busy), 64'(1'b0));

        run_op("mul_7x-3",     3'd0, 32'd7,         32'hFFFF_FFFD);
        run_op("mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_-7/2",     3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_-7/2",     3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100/7",   3'd5, 32'd100,       32'd7);
        run_op("remu_100/7",   3'd7, 32'd100,       32'd7);
        run_op("div_by_zero",  3'd4, 32'd5,         32'd0);
        run_op("remu_by_zero", 3'd7, 32'd5,         32'd0);
        run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_ovf_pat", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = rand_operand();
            rb  = rand_operand();
            run_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb);
        end

        // start during the iteration is ignored; a start in the done cycle
        // is accepted immediately.
        issue(3'd0, 32'h1234_5678, 32'h0000_9ABC);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start     = 1'b1;
        muldiv_op = 3'd5;
        op_a      = 32'd1000;
        op_b      = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, lat, busy_ok);
        check("busy_start/latency", 64'(lat), 64'd33);
        check("busy_start/result", 64'(result), 64'(ref_res(3'd0, 32'h1234_5678, 32'h0000_9ABC)));
        check("busy_start/busy_held", 64'(busy_ok), 64'(1'b1));
        issue(3'd6, 32'hFFFF_FF00, 32'd7);
        check("b2b/busy_at_start", 64'(busy), 64'(1'b1));
        wait_done(1, lat, busy_ok);
        check("b2b/latency", 64'(lat), 64'd33);
        check("b2b/result", 64'(result), 64'(ref_res(3'd6, 32'hFFFF_FF00, 32'd7)));
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("b2b/no_extra_done", 64'(pulses), 64'd0);

        // reset in the middle of an operation discards it
        issue(3'd0, 32'd9, 32'd9);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset/busy", 64'(busy), 64'(1'b0));
        check("midreset/result", 64'(result), 64'h0);
        check("midreset/done", 64'(done), 64'(1'b0));
        rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midreset/no_done", 64'(pulses), 64'd0);
        run_op("after_reset_mul", 3'd0, 32'd6, 32'd7);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset.
REQ-004 Port: start  input  1  request; driven by is_muldiv qualified with instruction valid.
REQ-005 Port: muldiv_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: op_a  input  32  rs1 value (multiplicand/dividend).
REQ-007 Port: op_b  input  32  rs2 value (multiplier/divisor).
REQ-008 Port: busy  output  1  high while the FSM is not IDLE; the pipeline stalls on it.
REQ-009 Port: done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-010 Port: result  output  32  registered result; held stable until the next done.

Function
REQ-011 FSM SHALL have states IDLE, CALC, FIN; no other states.
REQ-012 In IDLE, start=1 at edge N SHALL capture muldiv_op, op_a and op_b and leave IDLE; start in any other state SHALL be ignored.
REQ-013 Capture SHALL convert operands to magnitudes and record the sign flags:
- a is signed for MULH, MULHSU, DIV, REM.
- b is signed for MULH, DIV, REM.
REQ-014 Normal path: edge N enters CALC with counter=0; edges N+1..N+32 perform 32 iterations; the iteration at counter=31 moves to FIN.
REQ-015 Multiply iteration SHALL be unsigned shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
REQ-016 Divide iteration SHALL be restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
REQ-017 FIN SHALL apply sign fix-up, register result, assert done for exactly one cycle and return to IDLE.
- Normal path: done is high from edge N+33 to edge N+34.
REQ-018 Sign rules:
- Product is negated when sign_a XOR sign_b.
- Quotient is negated when sign_a XOR sign_b.
- Remainder takes the sign of the dividend.
REQ-019 Result select:
- MUL: product[31:0].
- MULH, MULHSU, MULHU: product[63:32].
- DIV, DIVU: quotient.
- REM, REMU: remainder.
REQ-020 Divide by zero (op_b=0, ops 1xx) SHALL go from IDLE directly to FIN.
- DIV, DIVU: result 0xFFFFFFFF.
- REM, REMU: result op_a.
- done is high from edge N+1 to edge N+2.
REQ-021 Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF) SHALL take the same fast path.
- DIV: result 0x80000000.
- REM: result 0.
REQ-022 busy SHALL be 0 during the done cycle, so start is accepted back-to-back in that cycle.
REQ-023 All arithmetic SHALL be modulo 2^32 or 2^64 with no exceptions or flags.

Reset
REQ-024 rst_n=0 at any edge, including mid-CALC, SHALL force IDLE with busy=0, done=0, result=0 and counter=0; the operation in flight is discarded.
REQ-025 start sampled while rst_n=0 SHALL be ignored.

Structure
REQ-026 The shared package riscv_pkg SHALL hold XLEN and the eight muldiv_op encodings as named constants, also used by the ALU-control stage.
REQ-027 The FSM state encoding SHALL be local to muldiv_unit.
REQ-028 No sub-module is required; the datapath and FSM SHALL reside in the single module.

Verification
REQ-029 MUL op_a=7, op_b=0xFFFFFFFD, start at edge N -> done at N+33, result 0xFFFFFFEB; busy high from N to N+33.
REQ-030 High-product checks: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF; DIVU 100/7 -> 14 and REMU -> 2; each done at N+33.
REQ-032 Divide by zero: DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, done at N+1; overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, done at N+1.
REQ-033 start pulsed at N+5 during CALC -> ignored, a single done at N+33; a new start in the done cycle -> second done 33 cycles later.
REQ-034 rst_n=0 at N+10 -> at N+11 busy=0, result=0; no done pulse follows.
